// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
//
// Shared definitions for the instruction memory loader and the fetch side.
//   - loader_state_e : encoding of the loader FSM states
//   - BYTES_PER_WORD : number of memory bytes per 32-bit instruction word
//   - msbFirstByte() : byte-order rule; byte index 0 is the most significant
//                      byte and lives at the lowest address of the word
// ---------------------------------------------------------------------------
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } loader_state_e;

  // Big-endian byte selection: the fetch unit reassembles words in the same
  // order, so both sides must agree on this mapping.
  function automatic logic [7:0] msbFirstByte(input logic [31:0] word,
                                              input logic [1:0]  idx);
    logic [7:0] sel;
    case (idx)
      2'd0: sel = word[31:24];
      2'd1: sel = word[23:16];
      2'd2: sel = word[15:8];
      2'd3: sel = word[7:0];
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/imem_loader_serializer.sv
// ---------------------------------------------------------------------------
// word_byte_serializer
//
// Holds one 32-bit instruction word and steps through its four bytes in
// memory order, presenting a registered byte and its index within the word.
//
// Ports:
//   CLK        : clock, rising edge
//   Reset      : synchronous, active-low reset
//   load_i     : capture word_i and present byte 0 on the next cycle
//   step_i     : advance to the next byte (holds at the final byte)
//   word_i     : word to serialize
//   byteIdx_o  : index of the byte currently presented (0..3)
//   byte_o     : registered byte currently presented
//   lastByte_o : the presented byte is the final byte of the word
// ---------------------------------------------------------------------------
module word_byte_serializer
  import imem_loader_pkg::*;
(
  input  logic        CLK,
  input  logic        Reset,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] word_i,
  output logic [1:0]  byteIdx_o,
  output logic [7:0]  byte_o,
  output logic        lastByte_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  byte_q, byte_d;

  // A load takes priority over stepping: byte 0 of the incoming word is
  // selected straight from the input so it can be presented on the very next
  // cycle. Stepping stops at the last byte so the index never wraps back.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    byte_d = byte_q;
    if (load_i) begin
      word_d = word_i;
      idx_d  = 2'd0;
      byte_d = msbFirstByte(word_i, 2'd0);
    end else if (step_i && (idx_q != 2'd3)) begin
      idx_d  = idx_q + 2'd1;
      byte_d = msbFirstByte(word_q, idx_q + 2'd1);
    end
  end

  // Holding registers; cleared on reset so the byte and index outputs read 0.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      word_q <= '0;
      idx_q  <= '0;
      byte_q <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      byte_q <= byte_d;
    end
  end

  assign byteIdx_o  = idx_q;
  assign byte_o     = byte_q;
  assign lastByte_o = (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Writer side of the byte-wide instruction memory. Accepts 32-bit words over
// a valid/ready stream and writes each as four consecutive bytes, MSB first,
// starting at address 0. Holds the CPU stalled (busy) until the image is in.
//
// Parameters:
//   DEPTH : memory size in bytes (multiple of 4, power of 2)
//   AW    : byte address width, log2(DEPTH)
//
// Ports:
//   CLK          : clock, rising edge
//   Reset        : synchronous, active-low reset
//   start        : one-cycle pulse, begins a load at address 0 (ignored if busy)
//   in_valid     : in_word / in_last are valid
//   in_ready     : loader accepts a word this cycle (decoded from state)
//   in_word      : instruction word
//   in_last      : current word is the final word of the image
//   mem_we       : memory write enable
//   mem_addr     : byte address of the write
//   mem_wdata    : byte to write
//   busy         : load in progress, drives the CPU stall
//   done         : image loaded, sticky until next start or reset
//   overflow     : image larger than DEPTH, sticky until next start or reset
//   words_loaded : number of words fully written
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_word,
  input  logic          in_last,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic [AW-2:0] words_loaded
);

  import imem_loader_pkg::*;

  loader_state_e state_q, state_d;

  logic [AW-1:0] base_q, base_d;
  logic          last_q, last_d;
  logic [AW-2:0] wordsLoaded_q, wordsLoaded_d;
  logic          done_q, done_d;
  logic          overflow_q, overflow_d;
  logic          memWe_q, memWe_d;
  logic          busy_q, busy_d;

  logic          accept;
  logic          memFull;
  logic [1:0]    byteIdx;
  logic [7:0]    byteOut;
  logic          lastByte;

  assign in_ready = (state_q == WAIT);
  assign accept   = in_ready && in_valid;

  // The word being written is the last one that fits when its base sits at
  // DEPTH-4; stepping past it would wrap the address back to 0.
  assign memFull = (base_q == AW'(DEPTH - BYTES_PER_WORD));

  word_byte_serializer u_serializer (
    .CLK        (CLK),
    .Reset      (Reset),
    .load_i     (accept),
    .step_i     (state_q == WRITE),
    .word_i     (in_word),
    .byteIdx_o  (byteIdx),
    .byte_o     (byteOut),
    .lastByte_o (lastByte)
  );

  // State register plus the registered outputs and datapath state. A reset
  // anywhere, including mid-word, drops every output to 0 immediately.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q       <= IDLE;
      base_q        <= '0;
      last_q        <= 1'b0;
      wordsLoaded_q <= '0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
      memWe_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      last_q        <= last_d;
      wordsLoaded_q <= wordsLoaded_d;
      done_q        <= done_d;
      overflow_q    <= overflow_d;
      memWe_q       <= memWe_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state logic. A word ends after its fourth byte; the latched last
  // flag wins over the full check so an exactly filled memory reports done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (in_valid) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (lastByte) begin
          if (last_q) begin
            state_d = FINISH;
          end else if (memFull) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output and datapath logic. Write enable and busy are computed from the
  // upcoming state so that their registers line up with that state.
  always_comb begin
    base_d        = base_q;
    last_d        = last_q;
    wordsLoaded_d = wordsLoaded_q;
    done_d        = done_q;
    overflow_d    = overflow_q;
    memWe_d       = (state_d == WRITE);
    busy_d        = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d        = '0;
          wordsLoaded_d = '0;
          done_d        = 1'b0;
          overflow_d    = 1'b0;
        end
      end
      WAIT: begin
        if (in_valid) begin
          last_d = in_last;
        end
      end
      WRITE: begin
        if (lastByte) begin
          wordsLoaded_d = wordsLoaded_q + (AW-1)'(1);
          base_d        = base_q + AW'(BYTES_PER_WORD);
          if (!last_q && memFull) begin
            overflow_d = 1'b1;
          end
        end
      end
      FINISH: begin
        done_d = 1'b1;
      end
    endcase
  end

  // The base is 4-aligned, so base+k is just the byte index in the low bits.
  assign mem_addr     = {base_q[AW-1:2], byteIdx};
  assign mem_wdata    = byteOut;
  assign mem_we       = memWe_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overflow     = overflow_q;
  assign words_loaded = wordsLoaded_q;

endmodule
